mux4_decoder4_unit: RTL and testbench

Combined 4:1 multiplexer and 2-to-4 one-hot decoder with combinational and registered outputs. The mux selects one of four data bits by a 2-bit select. The decoder asserts exactly one of four lines for a 2-bit code. The block is a small selection/addressing primitive for datapath and control logic that needs both an immediate result and a clock-aligned copy.

---
 rtl/mux4_decoder4_unit_if.sv | 30 +++
 rtl/mux4_decoder4_unit.sv | 80 ++++++++
 tb/tb_mux4_decoder4_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux4_decoder4_unit_if.sv
// Bus bundle for the 4:1 mux / 2-to-4 decoder unit.
// The master drives enable, data, select and code; the slave (the unit) returns
// the combinational and registered results.
interface mux4_decoder4_unit_if;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned DEC_W  = 4;

    logic              en;
    logic [DATA_W-1:0] in;
    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  code;
    logic              out_m;
    logic              o0;
    logic              o1;
    logic              o2;
    logic              o3;
    logic              out_m_q;
    logic [DEC_W-1:0]  dec_q;

    modport master (
        output en, in, sel, code,
        input  out_m, o0, o1, o2, o3, out_m_q, dec_q
    );

    modport slave (
        input  en, in, sel, code,
        output out_m, o0, o1, o2, o3, out_m_q, dec_q
    );
endinterface

// File: rtl/mux4_decoder4_unit.sv
// 4:1 bit multiplexer plus 2-to-4 one-hot decoder.
// Both results are available immediately and as a clock-aligned copy that is
// captured under en. Reset clears only the registered copies; the
// combinational results keep tracking their inputs during reset.
module mux4_decoder4_unit (
    input  logic                 clk,
    input  logic                 rst,
    mux4_decoder4_unit_if.slave  bus
);
    localparam int unsigned DATA_W = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned DEC_W  = 4;

    logic              out_m_c;
    logic [DEC_W-1:0]  dec_c;
    logic              out_m_d;
    logic              out_m_q;
    logic [DEC_W-1:0]  dec_d;
    logic [DEC_W-1:0]  dec_q;
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  code;

    assign data = bus.in;
    assign sel  = bus.sel;
    assign code = bus.code;

    // Mux: pick one data bit by select.
    always_comb begin
        out_m_c = 1'b0;
        unique case (sel)
            2'b00: out_m_c = data[0];
            2'b01: out_m_c = data[1];
            2'b10: out_m_c = data[2];
            2'b11: out_m_c = data[3];
            default: out_m_c = 1'b0;
        endcase
    end

    // Decoder: exactly one line high for every code; there is no idle state.
    always_comb begin
        dec_c = '0;
        unique case (code)
            2'b00: dec_c = 4'b0001;
            2'b01: dec_c = 4'b0010;
            2'b10: dec_c = 4'b0100;
            2'b11: dec_c = 4'b1000;
            default: dec_c = '0;
        endcase
    end

    // Next-state: capture the live results when enabled, otherwise hold.
    always_comb begin
        out_m_d = out_m_q;
        dec_d   = dec_q;
        if (bus.en) begin
            out_m_d = out_m_c;
            dec_d   = dec_c;
        end
    end

    // Registered copies; all-zero decoder value marks reset only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_m_q <= 1'b0;
            dec_q   <= '0;
        end else begin
            out_m_q <= out_m_d;
            dec_q   <= dec_d;
        end
    end

    assign bus.out_m   = out_m_c;
    assign bus.o0      = dec_c[0];
    assign bus.o1      = dec_c[1];
    assign bus.o2      = dec_c[2];
    assign bus.o3      = dec_c[3];
    assign bus.out_m_q = out_m_q;
    assign bus.dec_q   = dec_q;
endmodule

// File: tb/tb_mux4_decoder4_unit.sv
// Directed bench for mux4_decoder4_unit: one task per scenario, inline checks.
module tb_mux4_decoder4_unit;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mux4_decoder4_unit_if bus ();

    mux4_decoder4_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] dec_now();
        return {bus.o3, bus.o2, bus.o1, bus.o0};
    endfunction

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.en = 1'b1; bus.in = 4'b1111; bus.sel = 2'b11; bus.code = 2'b11;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_m_q !== 1'b0) begin
            errors++; $display("FAIL reset_out_m_q got=%b exp=0", bus.out_m_q);
        end
        checks++;
        if (bus.dec_q !== 4'b0000) begin
            errors++; $display("FAIL reset_dec_q got=%b exp=0000", bus.dec_q);
        end
        edge_settle();
        checks++;
        if (bus.dec_q !== 4'b0000 || bus.out_m_q !== 1'b0) begin
            errors++; $display("FAIL reset_hold_edge got=%b/%b exp=0/0000", bus.out_m_q, bus.dec_q);
        end
        checks++;
        if (bus.out_m !== 1'b1 || dec_now() !== 4'b1000) begin
            errors++; $display("FAIL reset_comb_live got=%b/%b exp=1/1000", bus.out_m, dec_now());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_comb_sweep();
        logic [3:0] v;
        logic       exp_m;
        logic [3:0] exp_d;
        bus.en = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 16; i++) begin
                v        = 4'(i);
                bus.in   = v;
                bus.sel  = 2'(s);
                bus.code = 2'(s);
                #1;
                exp_m = (s == 0) ? v[0] : (s == 1) ? v[1] : (s == 2) ? v[2] : v[3];
                exp_d = (s == 0) ? 4'b0001 : (s == 1) ? 4'b0010 : (s == 2) ? 4'b0100 : 4'b1000;
                checks++;
                if (bus.out_m !== exp_m) begin
                    errors++; $display("FAIL sweep_out_m sel=%0d in=%b got=%b exp=%b", s, v, bus.out_m, exp_m);
                end
                checks++;
                if (dec_now() !== exp_d) begin
                    errors++; $display("FAIL sweep_dec code=%0d got=%b exp=%b", s, dec_now(), exp_d);
                end
            end
        end
        bus.sel = 2'b10; bus.code = 2'b10; bus.in = 4'b0100; #1;
        checks++;
        if (bus.out_m !== 1'b1 || dec_now() !== 4'b0100) begin
            errors++; $display("FAIL sweep_example1 got=%b/%b exp=1/0100", bus.out_m, dec_now());
        end
        bus.in = 4'b1011; #1;
        checks++;
        if (bus.out_m !== 1'b0) begin
            errors++; $display("FAIL sweep_example2 got=%b exp=0", bus.out_m);
        end
    endtask

    task automatic test_latency();
        logic [3:0] exp_m;
        logic [3:0] exp_d [4];
        exp_m    = 4'b1010;
        exp_d[0] = 4'b0001; exp_d[1] = 4'b0010; exp_d[2] = 4'b0100; exp_d[3] = 4'b1000;
        @(negedge clk);
        rst = 1'b0; bus.en = 1'b1; bus.in = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.sel = 2'(k); bus.code = 2'(k);
            edge_settle();
            checks++;
            if (bus.out_m_q !== exp_m[k]) begin
                errors++; $display("FAIL latency_out_m_q step=%0d got=%b exp=%b", k, bus.out_m_q, exp_m[k]);
            end
            checks++;
            if (bus.dec_q !== exp_d[k]) begin
                errors++; $display("FAIL latency_dec_q step=%0d got=%b exp=%b", k, bus.dec_q, exp_d[k]);
            end
        end
        // Between edges the registers must not follow a new select.
        @(negedge clk);
        bus.sel = 2'b00; bus.code = 2'b00; #1;
        checks++;
        if (bus.out_m_q !== 1'b1 || bus.dec_q !== 4'b1000) begin
            errors++; $display("FAIL latency_no_early got=%b/%b exp=1/1000", bus.out_m_q, bus.dec_q);
        end
    endtask

    task automatic test_enable_hold();
        @(negedge clk);
        bus.en = 1'b1; bus.sel = 2'b01; bus.in = 4'b0010; bus.code = 2'b01;
        edge_settle();
        checks++;
        if (bus.out_m_q !== 1'b1 || bus.dec_q !== 4'b0010) begin
            errors++; $display("FAIL hold_capture got=%b/%b exp=1/0010", bus.out_m_q, bus.dec_q);
        end
        @(negedge clk);
        bus.en = 1'b0; bus.sel = 2'b00; bus.code = 2'b11; #1;
        checks++;
        if (bus.out_m !== 1'b0 || dec_now() !== 4'b1000) begin
            errors++; $display("FAIL hold_comb_live got=%b/%b exp=0/1000", bus.out_m, dec_now());
        end
        for (int e = 0; e < 3; e++) begin
            edge_settle();
            checks++;
            if (bus.out_m_q !== 1'b1 || bus.dec_q !== 4'b0010) begin
                errors++; $display("FAIL hold_edge%0d got=%b/%b exp=1/0010", e, bus.out_m_q, bus.dec_q);
            end
        end
        @(negedge clk);
        bus.en = 1'b1;
        edge_settle();
        checks++;
        if (bus.out_m_q !== 1'b0 || bus.dec_q !== 4'b1000) begin
            errors++; $display("FAIL hold_reenable got=%b/%b exp=0/1000", bus.out_m_q, bus.dec_q);
        end
    endtask

    task automatic test_independent();
        @(negedge clk);
        bus.en = 1'b1; bus.sel = 2'b11; bus.code = 2'b00; bus.in = 4'b1000; #1;
        checks++;
        if (bus.out_m !== 1'b1 || dec_now() !== 4'b0001) begin
            errors++; $display("FAIL indep_comb got=%b/%b exp=1/0001", bus.out_m, dec_now());
        end
        edge_settle();
        checks++;
        if (bus.out_m_q !== 1'b1 || bus.dec_q !== 4'b0001) begin
            errors++; $display("FAIL indep_reg got=%b/%b exp=1/0001", bus.out_m_q, bus.dec_q);
        end
    endtask

    task automatic test_async_reset_mid();
        @(negedge clk);
        bus.en = 1'b1; bus.in = 4'b1111; bus.sel = 2'b11; bus.code = 2'b11;
        edge_settle();
        checks++;
        if (bus.out_m_q !== 1'b1 || bus.dec_q !== 4'b1000) begin
            errors++; $display("FAIL async_preload got=%b/%b exp=1/1000", bus.out_m_q, bus.dec_q);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_m_q !== 1'b0 || bus.dec_q !== 4'b0000) begin
            errors++; $display("FAIL async_mid_cycle got=%b/%b exp=0/0000", bus.out_m_q, bus.dec_q);
        end
        checks++;
        if (bus.out_m !== 1'b1 || dec_now() !== 4'b1000) begin
            errors++; $display("FAIL async_comb_live got=%b/%b exp=1/1000", bus.out_m, dec_now());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_coincident();
        @(negedge clk);
        bus.en = 1'b1; bus.in = 4'b1111; bus.sel = 2'b01; bus.code = 2'b01;
        edge_settle();
        @(negedge clk);
        bus.sel = 2'b10; bus.code = 2'b10;
        #5 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_m_q !== 1'b0 || bus.dec_q !== 4'b0000) begin
            errors++; $display("FAIL coincide_edge got=%b/%b exp=0/0000", bus.out_m_q, bus.dec_q);
        end
        edge_settle();
        checks++;
        if (bus.out_m_q !== 1'b0 || bus.dec_q !== 4'b0000) begin
            errors++; $display("FAIL coincide_held got=%b/%b exp=0/0000", bus.out_m_q, bus.dec_q);
        end
        @(negedge clk);
        rst = 1'b0; #1;
        checks++;
        if (bus.out_m_q !== 1'b0 || bus.dec_q !== 4'b0000) begin
            errors++; $display("FAIL coincide_release got=%b/%b exp=0/0000", bus.out_m_q, bus.dec_q);
        end
        edge_settle();
        checks++;
        if (bus.out_m_q !== 1'b1 || bus.dec_q !== 4'b0100) begin
            errors++; $display("FAIL coincide_first_load got=%b/%b exp=1/0100", bus.out_m_q, bus.dec_q);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.en = 1'b0; bus.in = '0; bus.sel = '0; bus.code = '0;
        test_reset();
        test_comb_sweep();
        test_latency();
        test_enable_hold();
        test_independent();
        test_async_reset_mid();
        test_reset_coincident();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
